// File: rtl/csi_if.sv
// Dual-channel CSI video front end: SOF alignment and pixel lockstep of two
// AXI4-Stream inputs into one merged stereo stream, with a small register bank.
module csi_if (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ibus_cs,
  input  logic        ibus_wr,
  input  logic [7:0]  ibus_addr,
  input  logic [31:0] ibus_wrdata,
  output logic [31:0] ibus_rddata,
  output logic        vrst_n,
  input  logic        tvalid_ch1,
  output logic        tready_ch1,
  input  logic        tuser_ch1,
  input  logic        tlast_ch1,
  input  logic [15:0] tdata_ch1,
  input  logic [3:0]  tdest_ch1,
  input  logic        tvalid_ch2,
  output logic        tready_ch2,
  input  logic        tuser_ch2,
  input  logic        tlast_ch2,
  input  logic [15:0] tdata_ch2,
  input  logic [3:0]  tdest_ch2,
  output logic        sof_out,
  output logic        vout,
  output logic [15:0] d1_out,
  output logic [15:0] d2_out
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_STREAM   = 2'd2
  } state_t;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_FCNT   = 8'h08;
  localparam logic [7:0] A_SIZE   = 8'h0C;

  state_t      state, state_nx;
  logic [1:0]  ctrl_q;
  logic        align_err, last_err;
  logic [31:0] frame_cnt;
  logic [31:0] size_q;
  logic [15:0] line_cnt, pix_cnt, last_pix;
  logic [31:0] rd_mux;

  logic en;
  logic fire;
  logic hold1, hold2, both_sof;
  logic out_fire, out_sof, align_set, last_set;
  logic wr_ctrl, wr_status;
  logic unused_ok;

  assign unused_ok = ^{tdest_ch1, tdest_ch2, ibus_wrdata[31:3]};

  assign en        = ctrl_q[0];
  assign vrst_n    = ctrl_q[1];
  assign wr_ctrl   = ibus_cs & ibus_wr & (ibus_addr == A_CTRL);
  assign wr_status = ibus_cs & ibus_wr & (ibus_addr == A_STATUS);

  assign hold1    = tvalid_ch1 & tuser_ch1;
  assign hold2    = tvalid_ch2 & tuser_ch2;
  assign both_sof = hold1 & hold2;
  assign fire     = tvalid_ch1 & tvalid_ch2 & tready_ch1 & tready_ch2;

  assign out_sof  = out_fire & tuser_ch1 & tuser_ch2;
  assign last_set = out_fire & (tlast_ch1 ^ tlast_ch2);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    tready_ch1 = 1'b0;
    tready_ch2 = 1'b0;
    out_fire   = 1'b0;
    align_set  = 1'b0;
    case (state)
      S_IDLE: begin
        tready_ch1 = 1'b1;
        tready_ch2 = 1'b1;
        if (en) state_nx = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (!en) begin
          tready_ch1 = 1'b1;
          tready_ch2 = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          // Non-SOF beats drain freely; a SOF beat is parked until its partner arrives.
          tready_ch1 = ~hold1 | both_sof;
          tready_ch2 = ~hold2 | both_sof;
          if (both_sof) begin
            out_fire = 1'b1;
            state_nx = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        tready_ch1 = en & tvalid_ch2;
        tready_ch2 = en & tvalid_ch1;
        if (!en) begin
          state_nx = S_IDLE;
        end else if (fire) begin
          if (tuser_ch1 ^ tuser_ch2) begin
            align_set = 1'b1;
            state_nx  = S_WAIT_SOF;
          end else begin
            out_fire = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout    <= 1'b0;
      sof_out <= 1'b0;
      d1_out  <= '0;
      d2_out  <= '0;
    end else begin
      vout    <= out_fire;
      sof_out <= out_sof;
      if (out_fire) begin
        d1_out <= tdata_ch1;
        d2_out <= tdata_ch2;
      end
    end
  end

  // ------------------------------------------------------ frame geometry
  // SIZE is snapshotted on the SOF beat so it describes the frame just closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      size_q    <= '0;
      line_cnt  <= '0;
      pix_cnt   <= '0;
      last_pix  <= '0;
    end else if (out_fire) begin
      if (out_sof) begin
        frame_cnt <= frame_cnt + 32'd1;
        size_q    <= {line_cnt, last_pix};
        line_cnt  <= tlast_ch1 ? 16'd1 : 16'd0;
        pix_cnt   <= tlast_ch1 ? 16'd0 : 16'd1;
        last_pix  <= tlast_ch1 ? 16'd1 : 16'd0;
      end else if (tlast_ch1) begin
        line_cnt <= line_cnt + 16'd1;
        last_pix <= pix_cnt + 16'd1;
        pix_cnt  <= '0;
      end else begin
        pix_cnt <= pix_cnt + 16'd1;
      end
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      align_err <= 1'b0;
      last_err  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= ibus_wrdata[1:0];
      align_err <= align_set | (align_err & ~(wr_status & ibus_wrdata[1]));
      last_err  <= last_set  | (last_err  & ~(wr_status & ibus_wrdata[2]));
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ibus_addr)
      A_CTRL:   rd_mux = {30'd0, ctrl_q};
      A_STATUS: rd_mux = {29'd0, last_err, align_err, (state == S_STREAM)};
      A_FCNT:   rd_mux = frame_cnt;
      A_SIZE:   rd_mux = size_q;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ibus_rddata <= '0;
    else if (ibus_cs) ibus_rddata <= rd_mux;
  end

endmodule

// File: tb/tb_csi_if.sv
// Directed bench for csi_if: per-channel beat queues feed the two AXIS inputs,
// merged output beats are collected and compared against hand-built frames.
module tb_csi_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ibus_cs, ibus_wr;
  logic [7:0]  ibus_addr;
  logic [31:0] ibus_wrdata;
  logic [31:0] ibus_rddata;
  logic        vrst_n;
  logic        tvalid_ch1, tready_ch1, tuser_ch1, tlast_ch1;
  logic [15:0] tdata_ch1;
  logic [3:0]  tdest_ch1;
  logic        tvalid_ch2, tready_ch2, tuser_ch2, tlast_ch2;
  logic [15:0] tdata_ch2;
  logic [3:0]  tdest_ch2;
  logic        sof_out, vout;
  logic [15:0] d1_out, d2_out;

  csi_if dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_cs(ibus_cs), .ibus_wr(ibus_wr), .ibus_addr(ibus_addr),
    .ibus_wrdata(ibus_wrdata), .ibus_rddata(ibus_rddata), .vrst_n(vrst_n),
    .tvalid_ch1(tvalid_ch1), .tready_ch1(tready_ch1), .tuser_ch1(tuser_ch1),
    .tlast_ch1(tlast_ch1), .tdata_ch1(tdata_ch1), .tdest_ch1(tdest_ch1),
    .tvalid_ch2(tvalid_ch2), .tready_ch2(tready_ch2), .tuser_ch2(tuser_ch2),
    .tlast_ch2(tlast_ch2), .tdata_ch2(tdata_ch2), .tdest_ch2(tdest_ch2),
    .sof_out(sof_out), .vout(vout), .d1_out(d1_out), .d2_out(d2_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // beat = {tuser, tlast, tdata}
  logic [17:0] q1[$];
  logic [17:0] q2[$];
  logic [32:0] outq[$];
  bit          gap1 = 0;
  bit          lat_en = 0;
  int          lat_errs = 0;
  logic        fired = 1'b0;
  int unsigned cyc = 0;

  // Channel sources: pop on handshake, present next beat at the falling edge.
  initial begin
    logic acc1, acc2;
    forever begin
      @(posedge clk);
      acc1  = tvalid_ch1 && tready_ch1;
      acc2  = tvalid_ch2 && tready_ch2;
      fired = acc1 && acc2;
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      if (acc2 && q2.size() > 0) void'(q2.pop_front());
      @(negedge clk);
      cyc++;
      if (q1.size() > 0 && ((tvalid_ch1 && !acc1) || !(gap1 && cyc[0]))) begin
        tvalid_ch1 = 1'b1;
        {tuser_ch1, tlast_ch1, tdata_ch1} = q1[0];
      end else begin
        tvalid_ch1 = 1'b0;
      end
      if (q2.size() > 0) begin
        tvalid_ch2 = 1'b1;
        {tuser_ch2, tlast_ch2, tdata_ch2} = q2[0];
      end else begin
        tvalid_ch2 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (vout) outq.push_back({sof_out, d1_out, d2_out});
    if (lat_en && (vout !== fired)) lat_errs++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    ibus_cs = 1'b1; ibus_wr = 1'b1; ibus_addr = a; ibus_wrdata = d;
    @(negedge clk); #1;
    ibus_cs = 1'b0; ibus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); #1;
    ibus_cs = 1'b1; ibus_wr = 1'b0; ibus_addr = a;
    @(negedge clk); #1;
    d = ibus_rddata;
    ibus_cs = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  // Frame beat i: data = base + fr*256 + i, SOF on beat 0, tlast at line ends.
  task automatic push_frame(input int ch, input int fr, input int lines, input int ppl,
                            input int bad_user, input int bad_last);
    for (int i = 0; i < lines * ppl; i++) begin
      logic u, l;
      logic [15:0] d;
      u = (i == 0) || (i == bad_user);
      l = ((i % ppl) == ppl - 1);
      if (i == bad_last) l = 1'b1;
      if (bad_last >= 0 && i == bad_last + 1) l = 1'b0;
      d = (ch == 1 ? 16'h1000 : 16'h2000) + 16'(fr * 256 + i);
      if (ch == 1) q1.push_back({u, l, d});
      else         q2.push_back({u, l, d});
    end
  endtask

  task automatic push_junk(input int n);
    for (int i = 0; i < n; i++) begin
      q1.push_back({2'b00, 16'hDE00 + 16'(i)});
      q2.push_back({2'b00, 16'hEE00 + 16'(i)});
    end
  endtask

  function automatic logic [32:0] exp_out(input int fr, input int k);
    return {(k == 0), 16'h1000 + 16'(fr * 256 + k), 16'h2000 + 16'(fr * 256 + k)};
  endfunction

  task automatic check_frame(input int start, input int fr, input int n);
    for (int k = 0; k < n; k++) begin
      logic [32:0] got;
      got = (start + k < outq.size()) ? outq[start + k] : 'x;
      chk($sformatf("f%0d_beat%0d", fr, k), {31'd0, got}, {31'd0, exp_out(fr, k)});
    end
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int c = 0;
    while ((q1.size() != 0 || q2.size() != 0) && c < maxc) begin
      tick(1);
      c++;
    end
    chk(tag, q1.size() + q2.size(), 0);
    tick(3);
  endtask

  task automatic wait_out(input string tag, input int n, input int maxc);
    int c = 0;
    while (outq.size() < n && c < maxc) begin
      tick(1);
      c++;
    end
    chk(tag, (outq.size() >= n), 1);
  endtask

  initial begin
    logic [31:0] d;
    int sz;
    rst_n = 1'b0;
    ibus_cs = 1'b0; ibus_wr = 1'b0; ibus_addr = '0; ibus_wrdata = '0;
    tvalid_ch1 = 1'b0; tuser_ch1 = 1'b0; tlast_ch1 = 1'b0; tdata_ch1 = '0; tdest_ch1 = '0;
    tvalid_ch2 = 1'b0; tuser_ch2 = 1'b0; tlast_ch2 = 1'b0; tdata_ch2 = '0; tdest_ch2 = '0;
    tick(4);
    rst_n = 1'b1;
    tick(2);

    // reset state
    chk("rst_vout", vout, 0);
    chk("rst_sof", sof_out, 0);
    chk("rst_vrst_n", vrst_n, 0);
    chk("rst_tready1", tready_ch1, 1);
    chk("rst_tready2", tready_ch2, 1);
    rd_chk("rst_ctrl", 8'h00, 32'h0);
    rd_chk("rst_status", 8'h04, 32'h0);
    rd_chk("rst_fcnt", 8'h08, 32'h0);
    rd_chk("rst_size", 8'h0C, 32'h0);
    rd_chk("bad_addr", 8'h10, 32'h0);

    // enable; right channel starts well before left and parks its SOF
    bus_write(8'h00, 32'h3);
    tick(1);
    chk("vrst_n_on", vrst_n, 1);
    rd_chk("ctrl_rb", 8'h00, 32'h3);
    tick(2);
    chk("rd_hold", ibus_rddata, 32'h3);
    q2.push_back({2'b00, 16'hEE00});
    q2.push_back({2'b00, 16'hEE01});
    push_frame(2, 0, 3, 4, -1, -1);
    tick(3000);
    chk("ch2_parked_tready", tready_ch2, 0);
    chk("ch2_parked_tvalid", tvalid_ch2, 1);
    chk("ch2_junk_dropped", q2.size(), 12);
    chk("no_out_before_sync", outq.size(), 0);
    q1.push_back({2'b00, 16'hDE00});
    push_frame(1, 0, 3, 4, -1, -1);
    wait_drain("drain_f0", 500);
    chk("f0_count", outq.size(), 12);
    check_frame(0, 0, 12);
    rd_chk("f0_fcnt", 8'h08, 32'd1);
    rd_chk("f0_status", 8'h04, 32'h1);

    // ch1 gapped every other cycle; vout must track fires with 1-clk latency
    outq.delete();
    gap1 = 1;
    lat_en = 1;
    push_frame(1, 1, 3, 4, -1, -1);
    push_frame(2, 1, 3, 4, -1, -1);
    wait_drain("drain_f1", 500);
    lat_en = 0;
    gap1 = 0;
    chk("latency_errs", lat_errs, 0);
    chk("f1_count", outq.size(), 12);
    check_frame(0, 1, 12);
    rd_chk("f1_fcnt", 8'h08, 32'd2);
    rd_chk("f1_size", 8'h0C, 32'h0003_0004);

    // stray SOF on ch1 at beat 5: pair dropped, resync on the next common SOF
    outq.delete();
    push_frame(1, 2, 3, 4, 5, -1);
    push_frame(2, 2, 3, 4, -1, -1);
    wait_drain("drain_f2", 500);
    chk("f2_count", outq.size(), 5);
    rd_chk("align_status", 8'h04, 32'h2);
    push_frame(1, 3, 3, 4, -1, -1);
    push_frame(2, 3, 3, 4, -1, -1);
    wait_drain("drain_f3", 500);
    chk("f3_count", outq.size(), 17);
    check_frame(0, 2, 5);
    check_frame(5, 3, 12);
    rd_chk("f3_status", 8'h04, 32'h3);
    rd_chk("f3_size", 8'h0C, 32'h0001_0004);
    rd_chk("f3_fcnt", 8'h08, 32'd4);
    bus_write(8'h04, 32'h2);
    rd_chk("align_w1c", 8'h04, 32'h1);

    // ch2 ends line 0 one pixel early: LAST_ERR, beats still output
    outq.delete();
    push_frame(1, 4, 2, 5, -1, -1);
    push_frame(2, 4, 2, 5, -1, 3);
    wait_drain("drain_f4", 500);
    chk("f4_count", outq.size(), 10);
    check_frame(0, 4, 10);
    rd_chk("last_status", 8'h04, 32'h5);
    push_frame(1, 5, 3, 4, -1, -1);
    push_frame(2, 5, 3, 4, -1, -1);
    wait_drain("drain_f5", 500);
    rd_chk("f5_size", 8'h0C, 32'h0002_0005);
    rd_chk("f5_fcnt", 8'h08, 32'd6);
    bus_write(8'h04, 32'h4);
    rd_chk("last_w1c", 8'h04, 32'h1);

    // EN cleared mid-frame: output stops, receivers drained
    outq.delete();
    push_frame(1, 6, 3, 4, -1, -1);
    push_frame(2, 6, 3, 4, -1, -1);
    wait_out("f6_started", 4, 200);
    bus_write(8'h00, 32'h2);
    tick(1);
    chk("en_off_vout", vout, 0);
    chk("en_off_tready1", tready_ch1, 1);
    chk("en_off_tready2", tready_ch2, 1);
    sz = outq.size();
    tick(8);
    chk("en_off_no_more_out", outq.size(), sz);
    wait_drain("drain_f6", 200);
    rd_chk("en_off_status", 8'h04, 32'h0);

    // re-enable mid-stream: nothing until the next SOF
    outq.delete();
    bus_write(8'h00, 32'h3);
    push_junk(3);
    push_frame(1, 7, 3, 4, -1, -1);
    push_frame(2, 7, 3, 4, -1, -1);
    wait_drain("drain_f7", 500);
    chk("f7_count", outq.size(), 12);
    check_frame(0, 7, 12);
    rd_chk("f7_fcnt", 8'h08, 32'd8);

    // asynchronous reset mid-frame
    outq.delete();
    push_frame(1, 8, 3, 4, -1, -1);
    push_frame(2, 8, 3, 4, -1, -1);
    wait_out("f8_started", 3, 200);
    rst_n = 1'b0;
    #1;
    chk("arst_vout", vout, 0);
    chk("arst_d1", d1_out, 0);
    chk("arst_vrst_n", vrst_n, 0);
    chk("arst_tready1", tready_ch1, 1);
    q1.delete();
    q2.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    rd_chk("arst_fcnt", 8'h08, 32'h0);
    rd_chk("arst_ctrl", 8'h00, 32'h0);
    rd_chk("arst_size", 8'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
